// File: rtl/jelly2_necolink_axi4_slave.sv
// Receive end of the necolink AXI4 write tunnel: RX message bytes -> AXI4 AW/W beats.
// Define JELLY2_NECOLINK_BRESP_EN to build the B-response serializer and source FIFO.
module jelly2_necolink_axi4_slave #(
    parameter int unsigned AXI4_ID_WIDTH   = 6,
    parameter int unsigned AXI4_ADDR_WIDTH = 64,
    parameter int unsigned AXI4_DATA_WIDTH = 64,
    parameter int unsigned AXI4_STRB_WIDTH = AXI4_DATA_WIDTH / 8,
    parameter int unsigned AXI4_LEN_WIDTH  = 8,
    parameter int unsigned AXI4_QOS_WIDTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cke,

    input  logic                       s_msg_rx_first,
    input  logic                       s_msg_rx_last,
    input  logic [7:0]                 s_msg_rx_src_node,
    input  logic [7:0]                 s_msg_rx_data,
    input  logic                       s_msg_rx_valid,

    output logic [7:0]                 m_msg_tx_dst_node,
    output logic [7:0]                 m_msg_tx_data,
    output logic                       m_msg_tx_valid,
    input  logic                       m_msg_tx_ready,

    output logic [AXI4_ID_WIDTH-1:0]   m_axi4_awid,
    output logic [AXI4_ADDR_WIDTH-1:0] m_axi4_awaddr,
    output logic [AXI4_LEN_WIDTH-1:0]  m_axi4_awlen,
    output logic [2:0]                 m_axi4_awsize,
    output logic [1:0]                 m_axi4_awburst,
    output logic                       m_axi4_awlock,
    output logic [3:0]                 m_axi4_awcache,
    output logic [2:0]                 m_axi4_awprot,
    output logic [AXI4_QOS_WIDTH-1:0]  m_axi4_awqos,
    output logic [3:0]                 m_axi4_awregion,
    output logic                       m_axi4_awvalid,
    input  logic                       m_axi4_awready,

    output logic [AXI4_DATA_WIDTH-1:0] m_axi4_wdata,
    output logic [AXI4_STRB_WIDTH-1:0] m_axi4_wstrb,
    output logic                       m_axi4_wlast,
    output logic                       m_axi4_wvalid,
    input  logic                       m_axi4_wready,

    input  logic [AXI4_ID_WIDTH-1:0]   m_axi4_bid,
    input  logic [1:0]                 m_axi4_bresp,
    input  logic                       m_axi4_bvalid,
    output logic                       m_axi4_bready,

    output logic                       err_overflow,
    output logic                       err_format
);

    localparam int unsigned DATA_BYTES = AXI4_DATA_WIDTH / 8;
    localparam int unsigned STRB_BYTES = (AXI4_STRB_WIDTH + 7) / 8;
    localparam int unsigned STRB_BITS  = STRB_BYTES * 8;
    localparam logic [7:0]  OP_AW       = 8'h10;
    localparam logic [7:0]  OP_W        = 8'h11;
    localparam logic [7:0]  AW_LAST_IDX = 8'd15;
    localparam logic [7:0]  W_LAST_IDX  = 8'(1 + DATA_BYTES + STRB_BYTES);
    localparam logic [7:0]  W_STRB_LO   = 8'(2 + DATA_BYTES);

    typedef enum logic [1:0] {ST_IDLE, ST_BODY, ST_SKIP} state_t;

    state_t                 state, state_next;
    logic   [7:0]           cnt, last_idx, src;
    logic                   op_aw, rx_en, known_op;
    logic                   aw_done, w_done, fmt_err, aw_take, w_take, fifo_full;
    logic   [15:0]          sh_id, sh_strb, strb_shift;
    logic   [63:0]          sh_addr;
    logic   [7:0]           sh_len, sh_b12, sh_size, sh_b14;
    logic                   sh_wlast;
    logic   [127:0]         sh_data;
    logic   [STRB_BITS-1:0] strb_bytes;

    assign rx_en      = cke & s_msg_rx_valid;
    assign known_op   = (s_msg_rx_data == OP_AW) || (s_msg_rx_data == OP_W);
    assign last_idx   = op_aw ? AW_LAST_IDX : W_LAST_IDX;
    assign strb_shift = {s_msg_rx_data, sh_strb[15:8]};
    assign strb_bytes = strb_shift[15 -: STRB_BITS];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else if (cke) begin
            state <= state_next;
        end
    end

    // Parser: a first byte always restarts; known opcodes are length-checked.
    always_comb begin
        state_next = state;
        aw_done    = 1'b0;
        w_done     = 1'b0;
        fmt_err    = 1'b0;
        if (rx_en) begin
            if (s_msg_rx_first) begin
                if (!known_op) begin
                    state_next = s_msg_rx_last ? ST_IDLE : ST_SKIP;
                end else if (s_msg_rx_last) begin
                    fmt_err    = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_BODY;
                end
            end else begin
                case (state)
                    ST_BODY: begin
                        if (s_msg_rx_last) begin
                            state_next = ST_IDLE;
                            if (cnt == last_idx) begin
                                aw_done = op_aw;
                                w_done  = !op_aw;
                            end else begin
                                fmt_err = 1'b1;
                            end
                        end else if (cnt == last_idx) begin
                            fmt_err    = 1'b1;
                            state_next = ST_SKIP;
                        end
                    end
                    ST_SKIP: begin
                        if (s_msg_rx_last) begin
                            state_next = ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= 8'd0;
            op_aw <= 1'b0;
            src   <= 8'd0;
        end else if (rx_en) begin
            if (s_msg_rx_first) begin
                cnt   <= 8'd1;
                op_aw <= (s_msg_rx_data == OP_AW);
                src   <= s_msg_rx_src_node;
            end else if (state == ST_BODY) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Multi-byte fields shift in from the top so little-endian bytes land in place.
    always_ff @(posedge clk) begin
        if (rx_en && !s_msg_rx_first && state == ST_BODY) begin
            if (op_aw) begin
                if (cnt <= 8'd2)        sh_id   <= {s_msg_rx_data, sh_id[15:8]};
                else if (cnt <= 8'd10)  sh_addr <= {s_msg_rx_data, sh_addr[63:8]};
                else if (cnt == 8'd11)  sh_len  <= s_msg_rx_data;
                else if (cnt == 8'd12)  sh_b12  <= s_msg_rx_data;
                else if (cnt == 8'd13)  sh_size <= s_msg_rx_data;
                else if (cnt == 8'd14)  sh_b14  <= s_msg_rx_data;
            end else begin
                if (cnt == 8'd1)            sh_wlast <= s_msg_rx_data[0];
                else if (cnt < W_STRB_LO)   sh_data  <= {s_msg_rx_data, sh_data[127:8]};
                else                        sh_strb  <= strb_shift;
            end
        end
    end

    assign aw_take = aw_done && (!m_axi4_awvalid || m_axi4_awready) && !fifo_full;
    assign w_take  = w_done && (!m_axi4_wvalid || m_axi4_wready);

    always_ff @(posedge clk) begin
        if (reset) begin
            m_axi4_awvalid  <= 1'b0;
            m_axi4_awid     <= '0;
            m_axi4_awaddr   <= '0;
            m_axi4_awlen    <= '0;
            m_axi4_awsize   <= '0;
            m_axi4_awburst  <= '0;
            m_axi4_awlock   <= 1'b0;
            m_axi4_awcache  <= '0;
            m_axi4_awprot   <= '0;
            m_axi4_awqos    <= '0;
            m_axi4_awregion <= '0;
        end else if (cke) begin
            if (aw_take) begin
                m_axi4_awvalid  <= 1'b1;
                m_axi4_awid     <= sh_id[AXI4_ID_WIDTH-1:0];
                m_axi4_awaddr   <= sh_addr[AXI4_ADDR_WIDTH-1:0];
                m_axi4_awlen    <= sh_len[AXI4_LEN_WIDTH-1:0];
                m_axi4_awsize   <= sh_size[2:0];
                m_axi4_awburst  <= sh_b12[1:0];
                m_axi4_awlock   <= sh_b12[2];
                m_axi4_awprot   <= sh_b12[6:4];
                m_axi4_awcache  <= sh_b14[3:0];
                m_axi4_awregion <= sh_b14[7:4];
                m_axi4_awqos    <= s_msg_rx_data[AXI4_QOS_WIDTH-1:0];
            end else if (m_axi4_awready) begin
                m_axi4_awvalid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_axi4_wvalid <= 1'b0;
            m_axi4_wdata  <= '0;
            m_axi4_wstrb  <= '0;
            m_axi4_wlast  <= 1'b0;
        end else if (cke) begin
            if (w_take) begin
                m_axi4_wvalid <= 1'b1;
                m_axi4_wdata  <= sh_data[127 -: AXI4_DATA_WIDTH];
                m_axi4_wstrb  <= strb_bytes[AXI4_STRB_WIDTH-1:0];
                m_axi4_wlast  <= sh_wlast;
            end else if (m_axi4_wready) begin
                m_axi4_wvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_format   <= 1'b0;
            err_overflow <= 1'b0;
        end else if (cke) begin
            if (fmt_err)                                        err_format   <= 1'b1;
            if ((aw_done && !aw_take) || (w_done && !w_take))   err_overflow <= 1'b1;
        end
    end

`ifdef JELLY2_NECOLINK_BRESP_EN
    logic [7:0]  fifo_mem [4];
    logic [1:0]  wr_ptr, rd_ptr, tx_idx;
    logic [2:0]  fifo_cnt;
    logic [7:0]  aw_src;
    logic [15:0] b_id;
    logic [1:0]  b_resp;
    logic        push, pop;
    logic        unused_sig;

    assign push       = cke & m_axi4_awvalid & m_axi4_awready;
    assign pop        = cke & m_axi4_bvalid & m_axi4_bready & (fifo_cnt != 3'd0);
    // A beat waiting in the AW register already owns a FIFO slot.
    assign fifo_full  = (fifo_cnt + 3'(m_axi4_awvalid)) >= 3'd4;
    assign unused_sig = ^{sh_id, sh_len, sh_b12, sh_size, sh_b14, sh_data, strb_shift, strb_bytes};

    always_ff @(posedge clk) begin
        if (cke && aw_take) aw_src <= src;
        if (push)           fifo_mem[wr_ptr] <= aw_src;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            fifo_cnt <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
        end
    end

    // B serializer: 0x12, id[7:0], id[15:8], resp; bready only while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_msg_tx_valid    <= 1'b0;
            m_msg_tx_data     <= 8'd0;
            m_msg_tx_dst_node <= 8'd0;
            m_axi4_bready     <= 1'b0;
            tx_idx            <= 2'd0;
            b_id              <= 16'd0;
            b_resp            <= 2'd0;
        end else if (cke) begin
            if (!m_msg_tx_valid) begin
                if (m_axi4_bvalid && m_axi4_bready) begin
                    m_msg_tx_valid    <= 1'b1;
                    m_msg_tx_data     <= 8'h12;
                    m_msg_tx_dst_node <= fifo_mem[rd_ptr];
                    m_axi4_bready     <= 1'b0;
                    tx_idx            <= 2'd0;
                    b_id              <= 16'(m_axi4_bid);
                    b_resp            <= m_axi4_bresp;
                end else begin
                    m_axi4_bready     <= 1'b1;
                end
            end else if (m_msg_tx_ready) begin
                tx_idx <= tx_idx + 2'd1;
                case (tx_idx)
                    2'd0:    m_msg_tx_data <= b_id[7:0];
                    2'd1:    m_msg_tx_data <= b_id[15:8];
                    2'd2:    m_msg_tx_data <= {6'd0, b_resp};
                    default: begin
                        m_msg_tx_valid <= 1'b0;
                        m_msg_tx_data  <= 8'd0;
                        m_axi4_bready  <= 1'b1;
                    end
                endcase
            end
        end
    end
`else
    logic unused_sig;

    assign fifo_full         = 1'b0;
    assign m_axi4_bready     = 1'b1;
    assign m_msg_tx_valid    = 1'b0;
    assign m_msg_tx_data     = 8'd0;
    assign m_msg_tx_dst_node = 8'd0;
    assign unused_sig = ^{sh_id, sh_len, sh_b12, sh_size, sh_b14, sh_data, strb_shift, strb_bytes,
                          src, m_axi4_bid, m_axi4_bresp, m_axi4_bvalid, m_msg_tx_ready};
`endif

endmodule

// File: doc/jelly2_necolink_axi4_slave.md
# jelly2_necolink_axi4_slave

- Receive-side end of the necolink AXI4 write tunnel.
- Parses incoming message bytes into AXI4 write-address (AW) and write-data (W) channel transfers, and drives them on an AXI4 master port toward local memory.
- Optionally serialises each AXI4 write response (B) back onto the necolink TX message stream to the originating node.
- Sits between the necolink RX/TX message layer and the local AXI4 interconnect.

## Interface
Parameters:
- AXI4_ID_WIDTH, 6, AW/B ID width (≤16)
- AXI4_ADDR_WIDTH, 64, address width (≤64)
- AXI4_DATA_WIDTH, 64, data width (multiple of 8, ≤128)
- AXI4_STRB_WIDTH, AXI4_DATA_WIDTH/8, strobe width
- AXI4_LEN_WIDTH, 8, burst length width (≤8)
- AXI4_QOS_WIDTH, 4, QoS width (≤8)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  clock
  - reset  in  1  synchronous active-high reset
- Clock enable:
  - cke  in  1  clock enable; when 0, all state holds and RX bytes are ignored
- Message RX and TX:
  - s_msg_rx_first/last/src_node[8]/data[8]/valid  in  RX message byte stream; no backpressure
  - m_msg_tx_dst_node[8]/data[8]/valid out, m_msg_tx_ready in  B-response byte stream
- AXI4 master:
  - m_axi4_aw{id,addr,len,size,burst,lock,cache,prot,qos,region,valid} out, awready in
  - m_axi4_w{data,strb,last,valid} out, wready in
  - m_axi4_b{id,resp,valid} in, bready out
- Error flags:
  - err_overflow  out  1  sticky: completed message dropped because its buffer was full
  - err_format  out  1  sticky: length mismatch on a known opcode

## Operation
- All multi-byte fields are little-endian. Byte index 0 of a message is the byte with first=1.
- Opcode 0x10, AW, 16 bytes:
  - [1..2] id, [3..10] addr, [11] len
  - [12] = {0, prot[2:0], 0, lock, burst[1:0]}
  - [13] size, [14] = {region, cache}, [15] qos
- Opcode 0x11, W, 2+D+S bytes, where D = DATA_WIDTH/8 and S = ceil(STRB_WIDTH/8):
  - [1] bit0 = last
  - next D bytes are data, then S bytes are strb
- Field truncation:
  - Fields wider than the parameter are truncated; upper bytes are ignored.
  - The unused bits of byte 12 are ignored.
- Parser FSM:
  - IDLE: a byte with first=1 latches the opcode and src_node, then goes to BODY (0x10/0x11) or SKIP (other opcodes).
  - BODY: the byte counter increments and fields load into a shadow register.
  - SKIP: bytes are discarded until last=1.
  - A byte with first=1 in any state restarts the parse at IDLE semantics.
  - On last=1 with count == expected length: the message commits to its buffer and the FSM returns to IDLE.
  - last=1 early, or count reaching the expected length without last: err_format is set, the message is discarded, and the FSM goes to SKIP (or IDLE if last=1).
- Buffers:
  - One single-entry output register each for AW and W.
  - Commit while the target buffer is valid and not emptied that same cycle: the message is dropped and err_overflow is set.
  - Commit in the same cycle the buffer handshakes (valid&ready) is accepted, with no bubble.
- B path:
  - A 4-entry FIFO of AW src_node, pushed on the AW handshake, supplies dst_node for responses (in-order B).
  - B response message: [0]=0x12, [1..2]=id, [3]=resp; 4 bytes sent back to back.
  - bready=1 only while the TX serializer is idle.
  - An AW commit is refused (overflow) while the src FIFO is full.

## Timing
- Reset values:
  - All valid outputs 0, m_axi4_bready 0, err flags 0.
  - FSM IDLE, FIFO empty, data outputs 0.
- Latency: aw/wvalid rises in the cycle after the last RX byte of a message.
- AXI outputs are held stable while valid&!ready. valid drops the cycle after the handshake unless a new commit happens in that same cycle.
- TX: each byte is held until m_msg_tx_ready. The B message occupies ≥4 cycles; the next bready rises the cycle after the last TX byte handshakes.
- Reset mid-message discards partial state. Bytes arriving after reset without first=1 are ignored (IDLE).
- cke=0 freezes the FSM, counters and outputs.

## Configuration
- JELLY2_NECOLINK_BRESP_EN defined: the B-response serializer and src FIFO are built as above.
- Not defined:
  - m_axi4_bready is tied 1; responses are discarded.
  - m_msg_tx_valid is tied 0, dst_node and data are tied 0.
  - The FIFO-full overflow condition does not exist.

## Test plan
- AW message with id=0x2A, addr=0x0123_4567_89AB_CDEF, len=3, byte12=0x25, size=3, byte14=0x53, qos=0x7, awready=1 -> one AW beat next cycle with identical fields (burst=1, lock=1, prot=2, cache=3, region=5).
- Four W messages with data 0x1..0x4, strb=0xFF, last on the 4th, wready toggling 1/0 -> four W beats in order, wlast only on the 4th, each held through the stalls.
- Two AW messages back to back with awready=0 -> the first is held, the second is dropped, err_overflow=1; raising awready yields only the first.
- AW message truncated to 12 bytes (last on byte 11) -> no AW beat, err_format=1; the next valid AW message is forwarded normally.
- With BRESP_EN, AW from src_node 0x05 id=0x2A, B with bresp=2 returned, tx_ready stalled 2 cycles -> TX bytes 0x12,0x2A,0x00,0x02 with dst_node=0x05, bready low until they complete.
- Opcode 0x77 for 20 bytes, then reset asserted mid-AW message -> no AXI activity and no error flags; all outputs at reset values.
